mux8_rr_sched: RTL

- Round-robin scheduler that sits directly upstream of the 8:1 4-bit mux (mux8).
- Watches 8 request lines and chooses one requester fairly.
- Drives the mux select, captures the mux output on the following cycle, and presents it downstream with a valid/ready handshake.
- Pulses a one-hot grant so the selected source knows its word has been taken.

---
 rtl/mux8_rr_sched_if.sv | 24 ++
 rtl/mux8_rr_sched.sv | 74 +++++++
 2 files changed

// File: rtl/mux8_rr_sched_if.sv
// Downstream valid/ready channel of the round-robin mux scheduler.
// master: drives out_valid/out_data/out_ch, takes out_ready; slave: reverse.
interface mux8_rr_sched_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_ch;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler in front of an 8:1 mux: picks a requester, drives
// the mux select, captures the mux output and forwards it over valid/ready.
// Ports: clk, reset (sync, active-low), req[7:0], sel[2:0] to mux s,
// y_in mux output, grant[7:0] one-hot pulse, dn = downstream channel.
module mux8_rr_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] y_in,
  output logic [7:0]       grant,
  mux8_rr_sched_if.master  dn
);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    HOLD
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] pick;

  // Scan from the far end back toward ptr so the
  // nearest set bit (in rotated order) wins.
  always_comb begin
    pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) pick = ptr + 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sel          <= 3'd0;
      ptr          <= 3'd0;
      grant        <= 8'd0;
      dn.out_valid <= 1'b0;
      dn.out_data  <= '0;
      dn.out_ch    <= 3'd0;
    end else begin
      // grant is high only while in SEL
      grant <= 8'd0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= pick;
            grant <= 8'd1 << pick;
            state <= SEL;
          end
        end
        SEL: begin
          dn.out_data  <= y_in;
          dn.out_ch    <= sel;
          dn.out_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (dn.out_ready) begin
            dn.out_valid <= 1'b0;
            ptr          <= dn.out_ch + 3'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
